// File: rtl/pdm_xcorr_lag_scan.sv
// pdm_xcorr_lag_scan
//   Multi-lag sliding-window cross-correlator for two 1-bit PDM streams.
//   For every lag L in -MAX_LAG..+MAX_LAG it keeps a running XOR mismatch
//   count over the last Leff accepted samples. Every RESULT_EVERY primed
//   samples it snapshots the counts and scans them one per cycle to find
//   the lag with the fewest mismatches (best alignment).
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   in_valid   data_1/data_2 are sampled this cycle when high
//   data_1     PDM stream A
//   data_2     PDM stream B
//   length     window length in samples (clamped to 2..MAX_LENGTH)
//   primed     window history full, results are meaningful
//   out_valid  one-cycle result strobe
//   best_lag   signed lag of minimum mismatch (positive: B lags A)
//   best_corr  mismatch count at best_lag
//   overrun    sticky, a result trigger arrived while a scan was busy
//
// Build option
//   PDM_XCORR_TIE_CENTER_EN: when defined, equal minimum counts are broken
//   towards the smaller |L| (negative L on equal |L|). When undefined the
//   most negative lag wins ties.
module pdm_xcorr_lag_scan #(
  parameter int MAX_LENGTH   = 256,
  parameter int MAX_LAG      = 4,
  parameter int RESULT_EVERY = 64,
  localparam int CW          = $clog2(MAX_LENGTH + 1),
  localparam int LAGW        = $clog2(MAX_LAG + 1) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   data_1,
  input  logic                   data_2,
  input  logic [CW-1:0]          length,
  output logic                   primed,
  output logic                   out_valid,
  output logic signed [LAGW-1:0] best_lag,
  output logic [CW-1:0]          best_corr,
  output logic                   overrun
);

  localparam int NUM_LAGS = 2 * MAX_LAG + 1;
  localparam int DEPTH    = MAX_LENGTH + 2 * MAX_LAG;
  localparam int IW       = $clog2(DEPTH);
  localparam int FW       = $clog2(DEPTH + 1);
  localparam int DW       = (RESULT_EVERY > 1) ? $clog2(RESULT_EVERY) : 1;
  localparam int XW       = $clog2(NUM_LAGS);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  // ---------------------------------------------------------------------
  // Effective window length and soft reset on change
  // ---------------------------------------------------------------------
  logic [CW-1:0] leff;
  logic [CW-1:0] length_q_reg;
  logic          soft_rst;
  logic          accept;
  logic          trigger;

  always_comb begin
    if (length < CW'(2))
      leff = CW'(2);
    else if (length > CW'(MAX_LENGTH))
      leff = CW'(MAX_LENGTH);
    else
      leff = length;
  end

  // Any change of the effective length restarts tracking; the sample
  // offered in that cycle is discarded.
  assign soft_rst = (leff != length_q_reg);
  assign accept   = in_valid && !soft_rst;

  // ---------------------------------------------------------------------
  // Histories, fill and decimation
  // ---------------------------------------------------------------------
  // Bit k holds the sample accepted k samples before the newest one.
  logic [DEPTH-1:0] hist1_reg;
  logic [DEPTH-1:0] hist2_reg;
  logic [FW-1:0]    fill_reg;
  logic [FW-1:0]    fill_next;
  logic [FW-1:0]    fill_target;
  logic             primed_reg;
  logic [DW-1:0]    dec_reg;
  logic             dec_wrap;

  assign fill_target = FW'(length_q_reg) + FW'(2 * MAX_LAG);
  assign fill_next   = (fill_reg == fill_target) ? fill_reg : fill_reg + FW'(1);
  assign dec_wrap    = (dec_reg == DW'(RESULT_EVERY - 1));
  assign trigger     = accept && primed_reg && dec_wrap;

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      hist1_reg    <= '0;
      hist2_reg    <= '0;
      fill_reg     <= '0;
      primed_reg   <= 1'b0;
      dec_reg      <= '0;
      length_q_reg <= leff;
    end else if (accept) begin
      hist1_reg  <= {hist1_reg[DEPTH-2:0], data_1};
      hist2_reg  <= {hist2_reg[DEPTH-2:0], data_2};
      fill_reg   <= fill_next;
      primed_reg <= (fill_next == fill_target);
      if (primed_reg)
        dec_reg <= dec_wrap ? '0 : dec_reg + DW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Per-lag running mismatch counters
  // ---------------------------------------------------------------------
  // The term entering the window pairs A at age MAX_LAG with B at age
  // MAX_LAG-L (ages after the shift). Expressed against the pre-shift
  // history, age a maps to bit a-1 and age 0 is the incoming bit. The
  // leaving term is the same pair Leff samples older.
  logic [CW-1:0] corr_next [NUM_LAGS];
  logic [IW-1:0] old1_idx;

  assign old1_idx = IW'(length_q_reg) + IW'(MAX_LAG - 1);

  generate
    for (genvar gi = 0; gi < NUM_LAGS; gi++) begin : g_lag
      localparam int A2 = 2 * MAX_LAG - gi;  // age of the B bit, lag gi-MAX_LAG
      logic          new_b;
      logic          m_new;
      logic          m_old;
      logic [IW-1:0] old2_idx;
      logic [CW-1:0] cnt_reg;

      if (A2 == 0) begin : g_age0
        assign new_b = data_2;
      end else begin : g_aged
        assign new_b = hist2_reg[A2-1];
      end

      assign old2_idx      = IW'(length_q_reg) + IW'(A2) - IW'(1);
      assign m_new         = hist1_reg[MAX_LAG-1] ^ new_b;
      assign m_old         = hist1_reg[old1_idx] ^ hist2_reg[old2_idx];
      assign corr_next[gi] = cnt_reg + CW'(m_new) - CW'(m_old);

      always_ff @(posedge clk) begin
        if (rst || soft_rst)
          cnt_reg <= '0;
        else if (accept)
          cnt_reg <= corr_next[gi];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Snapshot and sequential arg-min scan
  // ---------------------------------------------------------------------
  state_t                 state_reg;
  state_t                 state_next;
  logic [CW-1:0]          snap_reg [NUM_LAGS];
  logic [XW-1:0]          idx_reg;
  logic [CW-1:0]          min_val_reg;
  logic [XW-1:0]          min_idx_reg;
  logic [CW-1:0]          cand;
  logic                   better;
  logic                   scan_last;
  logic [CW-1:0]          sel_val;
  logic [XW-1:0]          sel_idx;
  logic signed [LAGW-1:0] sel_lag;
  logic signed [LAGW-1:0] best_lag_reg;
  logic [CW-1:0]          best_corr_reg;
  logic                   overrun_reg;

  // |L| for a scan index, used only by the centre tie-break.
  function automatic logic [XW-1:0] lag_mag(input logic [XW-1:0] i);
    return (i >= XW'(MAX_LAG)) ? i - XW'(MAX_LAG) : XW'(MAX_LAG) - i;
  endfunction

  assign cand      = snap_reg[idx_reg];
  assign scan_last = (idx_reg == XW'(NUM_LAGS - 1));

  always_comb begin
    // Index 0 seeds the running minimum.
    better = (idx_reg == '0) || (cand < min_val_reg);
`ifdef PDM_XCORR_TIE_CENTER_EN
    // Ordering by (count, |L|); scanning upward from the most negative lag
    // means a strict compare already prefers negative L on equal |L|.
    if (cand == min_val_reg && lag_mag(idx_reg) < lag_mag(min_idx_reg))
      better = 1'b1;
`endif
    sel_val = better ? cand : min_val_reg;
    sel_idx = better ? idx_reg : min_idx_reg;
    sel_lag = LAGW'(int'(sel_idx) - MAX_LAG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAGS; i++)
        snap_reg[i] <= '0;
    end else if (state_reg == S_IDLE && trigger) begin
      // Post-update counts, so the triggering sample is included.
      for (int i = 0; i < NUM_LAGS; i++)
        snap_reg[i] <= corr_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      min_val_reg   <= '0;
      min_idx_reg   <= '0;
      best_lag_reg  <= '0;
      best_corr_reg <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      if (trigger && state_reg != S_IDLE)
        overrun_reg <= 1'b1;
      if (state_reg == S_SCAN) begin
        idx_reg     <= idx_reg + XW'(1);
        min_val_reg <= sel_val;
        min_idx_reg <= sel_idx;
      end else begin
        idx_reg <= '0;
      end
      // Results land as DONE is entered, so they are visible with out_valid.
      if (state_reg == S_SCAN && state_next == S_DONE) begin
        best_lag_reg  <= sel_lag;
        best_corr_reg <= sel_val;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // FSM: next state. A length change aborts a scan silently.
  always_comb begin
    state_next = state_reg;
    if (soft_rst) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (trigger) state_next = S_SCAN;
        S_SCAN:  if (scan_last) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state_reg == S_DONE);
  end

  assign primed    = primed_reg;
  assign overrun   = overrun_reg;
  assign best_lag  = best_lag_reg;
  assign best_corr = best_corr_reg;

endmodule

// File: tb/tb_pdm_xcorr_lag_scan.sv
// Testbench for pdm_xcorr_lag_scan. Stimulus tasks push expected results
// into a scoreboard when they issue a triggering sample; an independent
// monitor pops and compares whenever out_valid is seen.
module tb_pdm_xcorr_lag_scan;

  localparam int MAX_LENGTH   = 16;
  localparam int MAX_LAG      = 2;
  localparam int RESULT_EVERY = 32;
  localparam int CW           = $clog2(MAX_LENGTH + 1);
  localparam int LAGW         = $clog2(MAX_LAG + 1) + 1;
  localparam int NUM_LAGS     = 2 * MAX_LAG + 1;
`ifdef PDM_XCORR_TIE_CENTER_EN
  localparam int TIE_LAG = 0;
`else
  localparam int TIE_LAG = -2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic data_1 = 1'b0;
  logic data_2 = 1'b0;
  logic [CW-1:0] length = CW'(16);

  logic                   primed, out_valid, overrun;
  logic signed [LAGW-1:0] best_lag;
  logic [CW-1:0]          best_corr;
  logic                   primed_b, out_valid_b, overrun_b;
  logic signed [LAGW-1:0] best_lag_b;
  logic [CW-1:0]          best_corr_b;

  pdm_xcorr_lag_scan #(.MAX_LENGTH(MAX_LENGTH), .MAX_LAG(MAX_LAG), .RESULT_EVERY(RESULT_EVERY)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_1(data_1), .data_2(data_2),
    .length(length), .primed(primed), .out_valid(out_valid), .best_lag(best_lag),
    .best_corr(best_corr), .overrun(overrun)
  );

  // Fast-trigger instance used only to exercise overrun.
  pdm_xcorr_lag_scan #(.MAX_LENGTH(MAX_LENGTH), .MAX_LAG(MAX_LAG), .RESULT_EVERY(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_1(data_1), .data_2(data_2),
    .length(length), .primed(primed_b), .out_valid(out_valid_b), .best_lag(best_lag_b),
    .best_corr(best_corr_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int lag;
    int corr;
    int due;
  } exp_t;
  exp_t sb_q[$];

  // Control-path model and expected result for the running test.
  int   leff_m = 16;
  int   fill_m = 0;
  int   dec_m = 0;
  logic primed_m = 1'b0;
  int   exp_lag = 0;
  int   exp_corr = 0;

  // Stream source: maximal-length 7-bit LFSR plus two delay taps.
  logic [6:0] lfsr_s = 7'h5A;
  logic       p1 = 1'b0;
  logic       p2 = 1'b0;

  function automatic int clampl(input int l);
    if (l < 2) return 2;
    if (l > MAX_LENGTH) return MAX_LENGTH;
    return l;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected result, on time.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result cyc=%0d actual lag=%0d corr=%0d required none",
                 cyc, best_lag, best_corr);
      end else begin
        e = sb_q.pop_front();
        if (int'(best_lag) != e.lag || int'(best_corr) != e.corr || cyc != e.due) begin
          n_err++;
          $display("FAIL result cyc=%0d actual lag=%0d corr=%0d required lag=%0d corr=%0d at cyc=%0d",
                   cyc, best_lag, best_corr, e.lag, e.corr, e.due);
        end else begin
          $display("result cyc=%0d lag=%0d corr=%0d ok", cyc, best_lag, best_corr);
        end
      end
    end
  end

  // One cycle: entered at a negedge with data already set, returns at the
  // next negedge after checking primed.
  task automatic step(input logic v);
    logic trig;
    logic primed_after;
    int   nl;
    trig = 1'b0;
    in_valid = v;
    nl = clampl(int'(length));
    primed_after = primed_m;
    if (nl != leff_m) begin
      leff_m = nl;
      fill_m = 0;
      dec_m = 0;
      primed_after = 1'b0;
    end else if (v) begin
      if (primed_m) begin
        if (dec_m == RESULT_EVERY - 1) begin
          dec_m = 0;
          trig = 1'b1;
        end else begin
          dec_m++;
        end
      end
      if (fill_m < leff_m + 2 * MAX_LAG) fill_m++;
      primed_after = (fill_m == leff_m + 2 * MAX_LAG);
      if (trig) sb_q.push_back('{exp_lag, exp_corr, cyc + NUM_LAGS + 1});
    end
    @(posedge clk);
    primed_m = primed_after;
    @(negedge clk);
    chk("primed_track", int'(primed), int'(primed_m));
  endtask

  // mode: 0 identical, 1 B delayed 1, 2 B delayed 2, 3 A delayed 1,
  //       4 both 0, 5 A=1 B=0
  task automatic sample(input int mode, input logic v);
    logic s;
    s = 1'b0;
    if (v) begin
      lfsr_s = {lfsr_s[5:0], lfsr_s[6] ^ lfsr_s[5]};
      s = lfsr_s[0];
      case (mode)
        0:       begin data_1 = s;    data_2 = s;    end
        1:       begin data_1 = s;    data_2 = p1;   end
        2:       begin data_1 = s;    data_2 = p2;   end
        3:       begin data_1 = p1;   data_2 = s;    end
        4:       begin data_1 = 1'b0; data_2 = 1'b0; end
        default: begin data_1 = 1'b1; data_2 = 1'b0; end
      endcase
      p2 = p1;
      p1 = s;
    end else begin
      data_1 = 1'($urandom);
      data_2 = 1'($urandom);
    end
    step(v);
  endtask

  task automatic run(input int mode, input int n, input logic toggle);
    for (int i = 0; i < n; i++)
      sample(mode, toggle ? (i % 2 == 0) : 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < NUM_LAGS + 3; i++)
      sample(0, 1'b0);
  endtask

  task automatic do_reset();
    chk("sb_drained", sb_q.size(), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_1 = 1'($urandom);
      data_2 = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_primed", int'(primed), 0);
    chk("rst_best_lag", int'(best_lag), 0);
    chk("rst_best_corr", int'(best_corr), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_overrun_b", int'(overrun_b), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    leff_m = clampl(int'(length));
    fill_m = 0;
    dec_m = 0;
    primed_m = 1'b0;
    p1 = 1'b0;
    p2 = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Identical streams: primed at 20 samples, result 6 cycles after trigger.
    exp_lag = 0; exp_corr = 0;
    run(0, 19, 1'b0);
    chk("primed_before_fill", int'(primed), 0);
    run(0, 1, 1'b0);
    chk("primed_at_fill", int'(primed), 1);
    run(0, 64, 1'b0);
    drain();

    // Delayed streams.
    do_reset();
    exp_lag = 1; exp_corr = 0;
    run(1, 60, 1'b0);
    drain();
    do_reset();
    exp_lag = 2; exp_corr = 0;
    run(2, 60, 1'b0);
    drain();
    do_reset();
    exp_lag = -1; exp_corr = 0;
    run(3, 60, 1'b0);
    drain();

    // All-zero streams: every count ties at 0.
    do_reset();
    exp_lag = TIE_LAG; exp_corr = 0;
    run(4, 60, 1'b0);
    drain();

    // Length change mid-scan aborts the result; window 8 then window 2.
    do_reset();
    exp_lag = TIE_LAG; exp_corr = 16;
    run(5, 52, 1'b0);
    chk("abort_trigger_issued", sb_q.size(), 1);
    run(5, 2, 1'b0);
    void'(sb_q.pop_back());
    length = CW'(8);
    run(5, 1, 1'b0);
    chk("abort_primed_cleared", int'(primed), 0);
    run(5, 11, 1'b0);
    chk("len8_primed_11", int'(primed), 0);
    run(5, 1, 1'b0);
    chk("len8_primed_12", int'(primed), 1);
    exp_corr = 8;
    run(5, 32, 1'b0);
    drain();
    length = CW'(0);
    exp_corr = 2;
    run(5, 1, 1'b0);
    run(5, 5, 1'b0);
    chk("len0_primed_5", int'(primed), 0);
    run(5, 1, 1'b0);
    chk("len0_primed_6", int'(primed), 1);
    run(5, 34, 1'b0);
    drain();

    // Overrun on the fast-trigger instance; sticky across a length change.
    length = CW'(16);
    do_reset();
    exp_lag = 0; exp_corr = 0;
    run(0, 27, 1'b0);
    chk("overrun_before_2nd", int'(overrun_b), 0);
    run(0, 1, 1'b0);
    chk("overrun_at_2nd", int'(overrun_b), 1);
    run(0, 40, 1'b0);
    chk("overrun_held", int'(overrun_b), 1);
    chk("no_overrun_slow", int'(overrun), 0);
    length = CW'(12);
    run(0, 1, 1'b0);
    chk("overrun_after_len", int'(overrun_b), 1);
    length = CW'(16);
    run(0, 1, 1'b0);
    drain();

    // Gapped input: only accepted samples matter.
    do_reset();
    exp_lag = 2; exp_corr = 0;
    run(2, 120, 1'b1);
    drain();

    chk("sb_final_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
